// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage and architectural register file.
// Ports:
//   clock/reset_n        - rising-edge clock, async active-low reset
//   W_stat, W_in_code    - W-stage status and icode
//   W_dst_e/W_val_e      - ALU result write port (15 = none)
//   W_dst_m/W_val_m      - memory result write port (15 = none)
//   d_src_a/d_src_b      - decode read indices
//   d_rval_a/d_rval_b    - read data, 0 for index 15 or out of range
//   prog_stat, halted    - sticky architectural status, HALTED flag
//   retired              - retired-instruction counter
module writeback_regfile #(
    parameter int NREGS = 15,
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       W_stat,
    input  logic [3:0]       W_in_code,
    input  logic [3:0]       W_dst_e,
    input  logic [WIDTH-1:0] W_val_e,
    input  logic [3:0]       W_dst_m,
    input  logic [WIDTH-1:0] W_val_m,
    input  logic [3:0]       d_src_a,
    input  logic [3:0]       d_src_b,
    output logic [WIDTH-1:0] d_rval_a,
    output logic [WIDTH-1:0] d_rval_b,
    output logic [1:0]       prog_stat,
    output logic             halted,
    output logic [31:0]      retired
);

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] I_NOP    = 4'h1;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] regs [NREGS];
    logic [31:0]      retired_q;
    logic [1:0]       stat_q;
    logic             halted_q;

    logic run_ok;
    logic we_e;
    logic we_m;
    logic count;

    // Only an AOK instruction in RUN may touch architectural state.
    assign run_ok = (state == RUN) && (W_stat == STAT_AOK);

    assign we_e = run_ok && (W_dst_e != RNONE)
               && (32'(W_dst_e) < NREGS);
    assign we_m = run_ok && (W_dst_m != RNONE)
               && (32'(W_dst_m) < NREGS);

    assign count = run_ok && (W_in_code != I_NOP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            stat_q    <= STAT_AOK;
            halted_q  <= 1'b0;
            retired_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (W_stat != STAT_AOK) begin
                        state    <= HALTED;
                        stat_q   <= W_stat;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase

            if (count) begin
                retired_q <= retired_q + 32'd1;
            end

            // Port M is assigned last so it wins a collision
            // (popq %rsp leaves the popped value in %rsp).
            if (we_e) begin
                regs[W_dst_e] <= W_val_e;
            end
            if (we_m) begin
                regs[W_dst_m] <= W_val_m;
            end
        end
    end

    // No bypass: decode forwards from W itself.
    always_comb begin
        d_rval_a = '0;
        if (32'(d_src_a) < NREGS) begin
            d_rval_a = regs[d_src_a];
        end
    end

    always_comb begin
        d_rval_b = '0;
        if (32'(d_src_b) < NREGS) begin
            d_rval_b = regs[d_src_b];
        end
    end

    assign prog_stat = stat_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule
